tile_loader_mc: RTL

TILE_LOADER_MC -- requirements
Module: tile_loader_mc

---
 rtl/tile_loader_mc.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/tile_loader_mc.sv
// Tile loader: walks a strided 2-D region of DDR as 4 KB-safe read bursts and
// packs the returned words contiguously into one of NUM_CH on-chip buffers.
module tile_loader_mc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int BUF_ADDR_W = 16,
  parameter int MAX_BURST  = 16,
  localparam int WB        = DATA_W / 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CH_W-1:0]       cmd_ch,
  input  logic [ADDR_W-1:0]     cmd_base,
  input  logic [15:0]           cmd_rows,
  input  logic [15:0]           cmd_row_bytes,
  input  logic [31:0]           cmd_stride,
  input  logic [BUF_ADDR_W-1:0] cmd_dst,
  output logic                  rd_start_dma,
  output logic [ADDR_W-1:0]     rd_start_addr,
  output logic [7:0]            rd_num_trans,
  input  logic                  rd_done,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  rd_data_vld,
  output logic [NUM_CH-1:0]     buf_we,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0]     buf_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t r_state, w_next;

  logic [CH_W-1:0]       r_ch;
  logic [ADDR_W-1:0]     r_row_addr;
  logic [ADDR_W-1:0]     r_stride;
  logic [ADDR_W-1:0]     r_addr;
  logic [15:0]           r_rows;
  logic [15:0]           r_row_idx;
  logic [15:0]           r_row_words;
  logic [15:0]           r_rem;
  logic [15:0]           r_num;
  logic [15:0]           r_rcv;
  logic [BUF_ADDR_W-1:0] r_dst;
  logic [BUF_ADDR_W-1:0] r_word_cnt;

  logic                  r_cmd_ready;
  logic                  r_start;
  logic [NUM_CH-1:0]     r_buf_we;
  logic [BUF_ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0]     r_buf_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_capture;
  logic                  w_cmd_bad;
  logic [15:0]           w_rcv_now;
  logic                  w_burst_ok;
  logic [15:0]           w_rem_after;
  logic [ADDR_W-1:0]     w_issue_addr;
  logic [15:0]           w_issue_rem;
  logic [12:0]           w_to4k_bytes;
  logic [12:0]           w_to4k_words;
  logic [15:0]           w_beats;
  logic [NUM_CH-1:0]     w_ch_onehot;

  assign w_capture   = cmd_valid && r_cmd_ready;
  assign w_cmd_bad   = (cmd_rows == 16'd0) || (cmd_row_bytes == 16'd0) ||
                       ((cmd_row_bytes % 16'(WB)) != 16'd0) ||
                       ((cmd_base % ADDR_W'(WB)) != '0) ||
                       ({1'b0, cmd_ch} >= (CH_W+1)'(NUM_CH));
  // A beat arriving together with rd_done still counts toward this burst
  assign w_rcv_now   = r_rcv + {15'd0, rd_data_vld};
  assign w_burst_ok  = (w_rcv_now == r_num);
  assign w_rem_after = r_rem - r_num;
  assign w_ch_onehot = NUM_CH'(1) << r_ch;

  // Next burst either starts a fresh row or continues the current one
  always_comb begin
    w_issue_addr = r_row_addr;
    w_issue_rem  = r_row_words;
    if (r_state == S_WAIT) begin
      w_issue_addr = r_addr + ADDR_W'(r_num) * ADDR_W'(WB);
      w_issue_rem  = w_rem_after;
    end
  end

  assign w_to4k_bytes = 13'h1000 - {1'b0, w_issue_addr[11:0]};
  assign w_to4k_words = w_to4k_bytes / 13'(WB);

  always_comb begin
    w_beats = w_issue_rem;
    if (w_beats > 16'(MAX_BURST)) w_beats = 16'(MAX_BURST);
    if (w_beats > {3'd0, w_to4k_words}) w_beats = {3'd0, w_to4k_words};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_capture && !w_cmd_bad) w_next = S_ROW;
      S_ROW:   w_next = (r_row_idx == r_rows) ? S_FIN : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (rd_done) begin
          if (!w_burst_ok)               w_next = S_IDLE;
          else if (w_rem_after != 16'd0) w_next = S_ISSUE;
          else                           w_next = S_ROW;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ch        <= '0;
      r_row_addr  <= '0;
      r_stride    <= '0;
      r_addr      <= '0;
      r_rows      <= '0;
      r_row_idx   <= '0;
      r_row_words <= '0;
      r_rem       <= '0;
      r_num       <= '0;
      r_rcv       <= '0;
      r_dst       <= '0;
      r_word_cnt  <= '0;
      r_cmd_ready <= 1'b0;
      r_start     <= 1'b0;
      r_buf_we    <= '0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_start     <= (w_next == S_ISSUE);
      r_done      <= (w_next == S_FIN);
      r_err       <= 1'b0;
      r_buf_we    <= '0;

      if (w_capture) begin
        if (w_cmd_bad) begin
          r_err <= 1'b1;
        end else begin
          r_ch        <= cmd_ch;
          r_row_addr  <= cmd_base;
          r_stride    <= ADDR_W'(cmd_stride);
          r_rows      <= cmd_rows;
          r_row_words <= cmd_row_bytes / 16'(WB);
          r_dst       <= cmd_dst;
          r_row_idx   <= '0;
          r_word_cnt  <= '0;
        end
      end

      if (r_state == S_WAIT && rd_data_vld) begin
        r_buf_we    <= w_ch_onehot;
        r_buf_wdata <= rd_data;
        r_buf_addr  <= r_dst + r_word_cnt;
        r_word_cnt  <= r_word_cnt + 1'b1;
        r_rcv       <= w_rcv_now;
      end

      if (r_state == S_WAIT && rd_done && !w_burst_ok) r_err <= 1'b1;

      // Kept after the beat counter update so a new burst always starts at zero
      if (w_next == S_ISSUE) begin
        r_addr <= w_issue_addr;
        r_rem  <= w_issue_rem;
        r_num  <= w_beats;
        r_rcv  <= '0;
        if (r_state == S_ROW) begin
          r_row_addr <= r_row_addr + r_stride;
          r_row_idx  <= r_row_idx + 1'b1;
        end
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rd_start_dma  = r_start;
  assign rd_start_addr = r_addr;
  // A 256-beat burst encodes as 0 on the 8-bit length field
  assign rd_num_trans  = r_num[7:0];
  assign buf_we        = r_buf_we;
  assign buf_addr      = r_buf_addr;
  assign buf_wdata     = r_buf_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule
